// File: rtl/instream.sv
// Stimulus player for one TIS node input column: streams up to DEPTH latched-length
// values through a wready/read handshake and reports position, completion and SEND time.
module instream #(
    parameter int DEPTH = 39,
    parameter int WIDTH = 11,
    parameter int CW    = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [5:0]                   length,
    input  logic [DEPTH-1:0][WIDTH-1:0]  data,
    input  logic                         read,
    output logic                         wready,
    output logic [WIDTH-1:0]             value,
    output logic [5:0]                   pos,
    output logic                         complete,
    output logic [CW-1:0]                cycles,
    output logic [1:0]                   dbg_state
);

    // Handshake: a value moves to the node on every rising edge where wready=1 and
    // read=1; wready only depends on state, never combinationally on read.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [5:0] DEPTH_L = 6'(DEPTH);

    state_t               state_q, state_d;
    logic [5:0]           len_q, len_d;
    logic [5:0]           pos_q, pos_d;
    logic [WIDTH-1:0]     value_q, value_d;
    logic                 wready_q, wready_d;
    logic                 complete_q, complete_d;
    logic [CW-1:0]        cycles_q, cycles_d;

    logic [5:0]           len_clip;
    logic [5:0]           pos_inc;
    logic [WIDTH-1:0]     next_val;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        pos_d      = pos_q;
        value_d    = value_q;
        wready_d   = wready_q;
        complete_d = complete_q;
        cycles_d   = cycles_q;

        len_clip = (length > DEPTH_L) ? DEPTH_L : length;
        pos_inc  = pos_q + 6'd1;
        // Guard the lookahead index; it only reaches DEPTH on the final transfer.
        next_val = (pos_inc < DEPTH_L) ? data[pos_inc] : '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d = len_clip;
                    pos_d = 6'd0;
                    if (len_clip == 6'd0) begin
                        state_d    = DONE;
                        complete_d = 1'b1;
                    end else begin
                        state_d  = SEND;
                        wready_d = 1'b1;
                        value_d  = data[0];
                    end
                end
            end
            SEND: begin
                if (cycles_q != '1) begin
                    cycles_d = cycles_q + CW'(1);
                end
                if (read && wready_q) begin
                    pos_d = pos_inc;
                    if (pos_inc == len_q) begin
                        state_d    = DONE;
                        wready_d   = 1'b0;
                        value_d    = '0;
                        complete_d = 1'b1;
                    end else begin
                        value_d = next_val;
                    end
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            pos_q      <= '0;
            value_q    <= '0;
            wready_q   <= 1'b0;
            complete_q <= 1'b0;
            cycles_q   <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            pos_q      <= pos_d;
            value_q    <= value_d;
            wready_q   <= wready_d;
            complete_q <= complete_d;
            cycles_q   <= cycles_d;
        end
    end

    assign wready    = wready_q;
    assign value     = value_q;
    assign pos       = pos_q;
    assign complete  = complete_q;
    assign cycles    = cycles_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_instream.sv
// Randomized and directed bench for instream against a queue-based stream model.
module tb_instream;
    localparam int DEPTH = 39;
    localparam int WIDTH = 11;
    localparam int CW    = 16;

    logic                         clk = 1'b0;
    logic                         rst = 1'b1;
    logic                         start = 1'b0;
    logic [5:0]                   length = '0;
    logic [DEPTH-1:0][WIDTH-1:0]  data_v = '0;
    logic                         read = 1'b0;
    logic                         wready;
    logic [WIDTH-1:0]             value;
    logic [5:0]                   pos;
    logic                         complete;
    logic [CW-1:0]                cycles;
    logic [1:0]                   dbg_state;

    instream #(.DEPTH(DEPTH), .WIDTH(WIDTH), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .length(length), .data(data_v),
        .read(read), .wready(wready), .value(value), .pos(pos),
        .complete(complete), .cycles(cycles), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: mode 0 = waiting for start, 1 = streaming, 2 = finished.
    logic [WIDTH-1:0] exp_q[$];
    int m_mode   = 0;
    int m_len    = 0;
    int m_sent   = 0;
    int m_cycles = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_len = 0; m_sent = 0; m_cycles = 0;
        exp_q.delete();
    endtask

    task automatic model_edge(input logic rd, input logic st);
        if (m_mode == 0) begin
            if (st) begin
                m_len  = (int'(length) > DEPTH) ? DEPTH : int'(length);
                m_sent = 0;
                for (int i = 0; i < m_len; i++) exp_q.push_back(data_v[i]);
                m_mode = (m_len == 0) ? 2 : 1;
            end
        end else if (m_mode == 1) begin
            if (m_cycles < (1 << CW) - 1) m_cycles++;
            if (rd) begin
                void'(exp_q.pop_front());
                m_sent++;
                if (m_sent == m_len) m_mode = 2;
            end
        end
    endtask

    task automatic compare_outputs();
        check_eq("wready", {31'd0, wready}, (m_mode == 1) ? 32'd1 : 32'd0);
        check_eq("value", {21'd0, value}, (m_mode == 1) ? {21'd0, exp_q[0]} : 32'd0);
        check_eq("pos", {26'd0, pos}, 32'(m_sent));
        check_eq("complete", {31'd0, complete}, (m_mode == 2) ? 32'd1 : 32'd0);
        check_eq("cycles", {16'd0, cycles}, 32'(m_cycles));
    endtask

    // Called just after a falling edge: drive, score the transfer, clock, compare.
    task automatic step(input logic rd, input logic st);
        read  = rd;
        start = st;
        #1;
        if (rd && m_mode == 1) begin
            check_eq("xfer_value", {21'd0, value}, {21'd0, exp_q[0]});
        end
        @(posedge clk);
        model_edge(rd, st);
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        read = 1'b0; start = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_outputs();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load(input int n, input int v0, input int v1, input int v2, input int v3);
        for (int i = 0; i < DEPTH; i++) data_v[i] = WIDTH'($urandom);
        data_v[0] = WIDTH'(v0); data_v[1] = WIDTH'(v1);
        data_v[2] = WIDTH'(v2); data_v[3] = WIDTH'(v3);
        length = 6'(n);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        compare_outputs();

        // Three values with read held high
        load(3, 5, -7, 999, 0);
        step(1'b0, 1'b1);
        repeat (4) step(1'b1, 1'b0);
        check_eq("t1_cycles", {16'd0, cycles}, 32'd3);
        check_eq("t1_pos", {26'd0, pos}, 32'd3);

        // Reads spaced every fourth cycle
        do_reset();
        load(2, 1, 2, 0, 0);
        step(1'b0, 1'b1);
        repeat (2) begin
            repeat (3) step(1'b0, 1'b0);
            step(1'b1, 1'b0);
        end
        step(1'b0, 1'b0);
        check_eq("t2_cycles", {16'd0, cycles}, 32'd8);

        // Empty stream
        do_reset();
        load(0, 0, 0, 0, 0);
        step(1'b0, 1'b1);
        repeat (3) step(1'b1, 1'b0);
        check_eq("t3_complete", {31'd0, complete}, 32'd1);

        // Length above DEPTH is clipped
        do_reset();
        load(50, 1, 2, 3, 4);
        step(1'b0, 1'b1);
        repeat (42) step(1'b1, 1'b0);
        check_eq("t4_pos", {26'd0, pos}, 32'd39);

        // Reset mid-stream then replay from the start
        do_reset();
        load(4, 10, 20, 30, 40);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        do_reset();
        step(1'b0, 1'b1);
        check_eq("t5_replay", {21'd0, value}, 32'd10);
        repeat (5) step(1'b1, 1'b0);

        // Stray start/read pulses and an all-ones value
        do_reset();
        load(3, -1, 7, -1, 0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        check_eq("t6_neg1", {21'd0, value}, 32'h7FF);
        length = 6'd20;
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);

        // Randomized streams with random read gaps and stray starts
        for (int t = 0; t < 25; t++) begin
            do_reset();
            for (int i = 0; i < DEPTH; i++) data_v[i] = WIDTH'($urandom);
            length = 6'($urandom_range(0, 63));
            repeat ($urandom_range(0, 3)) step(1'($urandom_range(0, 1)), 1'b0);
            step(1'b0, 1'b1);
            for (int c = 0; c < 120; c++) begin
                length = 6'($urandom);
                step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
